// File: rtl/mr_if.sv
// Instruction fetch stage: credit-limited sequential word fetch into a small
// instruction FIFO, with redirect that flushes buffered and in-flight fetches.
module mr_if #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   out_cnt_nxt;
    logic [CW-1:0]   drop_cnt_nxt;

    logic [XLEN-1:0] infl_pc [MAX_OUTSTANDING];
    logic [QW-1:0]   infl_wr;
    logic [QW-1:0]   infl_rd;

    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0]   fifo_wr;
    logic [AW-1:0]   fifo_rd;
    logic [FW-1:0]   fifo_cnt;
    logic [FW-1:0]   fifo_cnt_nxt;
    logic            fifo_valid;

    logic            req_fire;
    logic            rsp_take;
    logic            rsp_keep;
    logic            pop_fire;

    function automatic logic [QW-1:0] infl_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; imem responses and jmp_valid are single-cycle strobes.
    always_comb begin
        // Credit rule: every request ever issued has a reserved FIFO slot.
        imem_req_valid = !rst && !jmp_valid
                         && (32'(out_cnt) < 32'(MAX_OUTSTANDING))
                         && ((32'(out_cnt) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH));
        imem_req_addr  = fetch_pc;

        req_fire = imem_req_valid && imem_req_ready;
        rsp_take = !rst && imem_rsp_valid && (out_cnt != '0);
        rsp_keep = rsp_take && !jmp_valid && (drop_cnt == '0);
        pop_fire = fifo_valid && inst_ready && !jmp_valid;

        out_cnt_nxt = out_cnt;
        if (req_fire && !rsp_take) begin
            out_cnt_nxt = out_cnt + 1'b1;
        end else if (!req_fire && rsp_take) begin
            out_cnt_nxt = out_cnt - 1'b1;
        end

        drop_cnt_nxt = drop_cnt;
        if (jmp_valid) begin
            drop_cnt_nxt = out_cnt - CW'(rsp_take);
        end else if (rsp_take && (drop_cnt != '0)) begin
            drop_cnt_nxt = drop_cnt - 1'b1;
        end

        fifo_cnt_nxt = fifo_cnt + FW'(rsp_keep) - FW'(pop_fire);
        if (jmp_valid) begin
            fifo_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            out_cnt    <= '0;
            drop_cnt   <= '0;
            infl_wr    <= '0;
            infl_rd    <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_cnt   <= '0;
            fifo_valid <= 1'b0;
        end else begin
            out_cnt    <= out_cnt_nxt;
            drop_cnt   <= drop_cnt_nxt;
            fifo_cnt   <= fifo_cnt_nxt;
            fifo_valid <= (fifo_cnt_nxt != '0);

            if (jmp_valid) begin
                fetch_pc <= {jmp_target[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end

            // In-flight PCs survive a redirect; stale responses still pop them.
            if (req_fire) infl_wr <= infl_inc(infl_wr);
            if (rsp_take) infl_rd <= infl_inc(infl_rd);

            if (jmp_valid) begin
                fifo_wr <= '0;
                fifo_rd <= '0;
            end else begin
                if (rsp_keep) fifo_wr <= fifo_wr + 1'b1;
                if (pop_fire) fifo_rd <= fifo_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            infl_pc[infl_wr] <= fetch_pc;
        end
        if (rsp_keep) begin
            fifo_data[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]   <= infl_pc[infl_rd];
        end
    end

    assign inst       = fifo_data[fifo_rd];
    assign inst_pc    = fifo_pc[fifo_rd];
    assign inst_valid = fifo_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rsp_with_credit: assert (!(imem_rsp_valid && (out_cnt == '0)));
            a_jmp_aligned:     assert (!(jmp_valid && (jmp_target[1:0] != 2'b00)));
            a_drop_le_out:     assert (drop_cnt <= out_cnt);
            a_fifo_bound:      assert (32'(fifo_cnt) <= 32'(FIFO_DEPTH));
            a_addr_aligned:    assert (imem_req_addr[1:0] == 2'b00);
        end
    end

endmodule
